uns_add_256_seq: RTL and testbench

//  Sequencer/initiator for the 256-bit serial unsigned adder datapath (16 x 16-bit words).

---
 rtl/uns_add_256_seq_pkg.sv | 20 ++
 rtl/uns_add_256_seq.sv | 143 ++++++++++++++
 tb/tb_uns_add_256_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uns_add_256_seq_pkg.sv
// Shared constants and state encoding for the 256-bit serial adder sequencer.
package uns_add_256_seq_pkg;

   localparam int WORDS = 16;
   localparam int W     = 16;
   localparam int CNT_W = $clog2(WORDS);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_A = 3'd1,
      S_LOAD_B = 3'd2,
      S_CLRC   = 3'd3,
      S_ADD    = 3'd4,
      S_OUT    = 3'd5
   } state_t;

endpackage

// File: rtl/uns_add_256_seq.sv
// Sequencer for the serial 256-bit adder: loads A then B word-serially, runs WORDS
// add cycles with carry chaining, then streams the sum words and the final carry.
module uns_add_256_seq
   import uns_add_256_seq_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic in_valid,
   output logic in_ready,
   input  logic out_ready,
   output logic out_valid,
   output logic out_last,
   input  logic carry_in,
   output logic carry_out,
   output logic busy,
   output logic rega_we,
   output logic rega_sel_cyc,
   output logic regb_we,
   output logic regb_sel_cyc,
   output logic dff_we,
   output logic carry_clr,
   output logic regs_we,
   output logic regs_sel_cyc
);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_out_q;
   logic             run;
   logic             cnt_last;
   logic             in_hs;
   logic             out_hs;

   // Strobes depend on the same-cycle handshake, so they are decoded from the
   // registered state and forced low while clr is high.
   always_comb begin
      run          = ~clr;
      cnt_last     = (cnt_q == CNT_LAST);
      in_ready     = run & ((state_q == S_IDLE) | (state_q == S_LOAD_A) | (state_q == S_LOAD_B));
      out_valid    = run & (state_q == S_OUT);
      out_last     = out_valid & cnt_last;
      busy         = run & (state_q != S_IDLE);
      in_hs        = in_valid & in_ready;
      out_hs       = out_valid & out_ready;
      rega_we      = 1'b0;
      rega_sel_cyc = 1'b0;
      regb_we      = 1'b0;
      regb_sel_cyc = 1'b0;
      dff_we       = 1'b0;
      carry_clr    = 1'b0;
      regs_we      = 1'b0;
      regs_sel_cyc = 1'b0;
      case (state_q)
         S_IDLE, S_LOAD_A: rega_we = in_hs;
         S_LOAD_B:         regb_we = in_hs;
         S_CLRC:           carry_clr = run;
         S_ADD: begin
            rega_we      = run;
            rega_sel_cyc = run;
            regb_we      = run;
            regb_sel_cyc = run;
            dff_we       = run;
            regs_we      = run;
         end
         S_OUT: begin
            regs_we      = out_hs;
            regs_sel_cyc = out_hs;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         carry_out_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_hs) begin
                  state_q <= S_LOAD_A;
                  cnt_q   <= CNT_ONE;
               end
            end
            S_LOAD_A: begin
               if (in_hs) begin
                  if (cnt_last) begin
                     state_q <= S_LOAD_B;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            S_LOAD_B: begin
               if (in_hs) begin
                  if (cnt_last) begin
                     state_q <= S_CLRC;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            S_CLRC: begin
               state_q <= S_ADD;
               cnt_q   <= '0;
            end
            S_ADD: begin
               if (cnt_last) begin
                  state_q <= S_OUT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_OUT: begin
               // The carry DFF took the final c_out on the last ADD edge and is
               // idle during OUT, so sampling it while cnt is 0 is stall-safe.
               if (cnt_q == '0) begin
                  carry_out_q <= carry_in;
               end
               if (out_hs) begin
                  if (cnt_last) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign carry_out = carry_out_q;

endmodule

// File: tb/tb_uns_add_256_seq.sv
// Bench for uns_add_256_seq: a behavioural word-serial datapath closes the loop and
// a scoreboard compares streamed sum words and the final carry against A+B.
`timescale 1ns/1ps
module tb_uns_add_256_seq;
   import uns_add_256_seq_pkg::*;

   logic clk = 1'b0;
   logic clr, in_valid, in_ready, out_ready, out_valid, out_last;
   logic carry_in, carry_out, busy;
   logic rega_we, rega_sel_cyc, regb_we, regb_sel_cyc, dff_we, carry_clr, regs_we, regs_sel_cyc;

   int tests_run    = 0;
   int tests_failed = 0;
   int load_a_cnt   = 0;
   int load_b_cnt   = 0;
   int stray_cnt    = 0;
   int op_id        = 0;

   logic [W-1:0] in_data = '0;
   logic [W-1:0] rega [WORDS] = '{default: '0};
   logic [W-1:0] regb [WORDS] = '{default: '0};
   logic [W-1:0] regs [WORDS] = '{default: '0};
   logic         cdff = 1'b0;
   logic [W:0]   add_w;
   logic [W-1:0] out_data;

   logic [W-1:0] sb_word[$];
   logic         sb_carry[$];

   always #5 clk = ~clk;

   uns_add_256_seq dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid), .out_last(out_last),
      .carry_in(carry_in), .carry_out(carry_out), .busy(busy),
      .rega_we(rega_we), .rega_sel_cyc(rega_sel_cyc), .regb_we(regb_we),
      .regb_sel_cyc(regb_sel_cyc), .dff_we(dff_we), .carry_clr(carry_clr),
      .regs_we(regs_we), .regs_sel_cyc(regs_sel_cyc)
   );

   // Behavioural datapath: shift in at the top, LSW at index 0, rotate by one word.
   assign add_w    = {1'b0, rega[0]} + {1'b0, regb[0]} + {{W{1'b0}}, cdff};
   assign out_data = regs[0];
   assign carry_in = cdff;

   always @(posedge clk) begin
      if (rega_we) begin
         for (int i = 0; i < WORDS - 1; i++) rega[i] <= rega[i+1];
         rega[WORDS-1] <= rega_sel_cyc ? rega[0] : in_data;
      end
      if (regb_we) begin
         for (int i = 0; i < WORDS - 1; i++) regb[i] <= regb[i+1];
         regb[WORDS-1] <= regb_sel_cyc ? regb[0] : in_data;
      end
      if (regs_we) begin
         for (int i = 0; i < WORDS - 1; i++) regs[i] <= regs[i+1];
         regs[WORDS-1] <= regs_sel_cyc ? regs[0] : add_w[W-1:0];
      end
      if (carry_clr)   cdff <= 1'b0;
      else if (dff_we) cdff <= add_w[W];
   end

   // Protocol monitor: load pulses, loads outside the input window, illegal strobe combinations.
   always @(posedge clk) begin
      if (rega_we && !rega_sel_cyc) load_a_cnt++;
      if (regb_we && !regb_sel_cyc) load_b_cnt++;
      if (((rega_we && !rega_sel_cyc) || (regb_we && !regb_sel_cyc)) && !in_ready) stray_cnt++;
      if (rega_we && regb_we && !rega_sel_cyc) stray_cnt++;
      if (carry_clr && dff_we) stray_cnt++;
      if (out_valid && !out_ready && regs_we) stray_cnt++;
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] strobes();
      return {rega_we, rega_sel_cyc, regb_we, regb_sel_cyc, dff_we, carry_clr, regs_we, regs_sel_cyc};
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send_op(input logic [255:0] a, input logic [255:0] b, input bit toggle);
      logic [256:0] s;
      logic [255:0] op;
      int guard;
      s = {1'b0, a} + {1'b0, b};
      for (int i = 0; i < WORDS; i++) sb_word.push_back(s[i*W +: W]);
      sb_carry.push_back(s[256]);
      for (int i = 0; i < 2*WORDS; i++) begin
         op = (i < WORDS) ? a : b;
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = op[(i % WORDS)*W +: W];
         guard = 0;
         while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 20) check_val("in_ready_timeout", in_ready, 1);
         @(posedge clk);
         if (toggle && i < 2*WORDS - 1) begin
            @(negedge clk);
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic recv_op(input int stall_idx, input int stall_len, input bit keep_valid, output int lat);
      logic [W-1:0] exp;
      int g;
      lat = 0;
      @(negedge clk);
      if (!keep_valid) in_valid = 1'b0;
      in_data = W'($urandom);
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
         if (keep_valid) in_data = W'($urandom);
      end
      for (int idx = 0; idx < WORDS; idx++) begin
         g = 0;
         while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
         end
         if (g >= 50) check_val("out_valid_timeout", out_valid, 1);
         if (sb_word.size() == 0) begin
            check_val("scoreboard_empty", 64'(sb_word.size()), 1);
            break;
         end
         exp = sb_word.pop_front();
         if (idx == stall_idx) begin
            out_ready = 1'b0;
            repeat (stall_len) begin
               @(negedge clk);
               check_val("hold_data", out_data, exp);
               check_val("hold_regs_we", regs_we, 0);
               check_val("hold_valid", out_valid, 1);
            end
            out_ready = 1'b1;
            #1;
         end
         check_val($sformatf("word%0d", idx), out_data, exp);
         check_val($sformatf("last%0d", idx), out_last, (idx == WORDS - 1));
         if (idx == WORDS - 1) check_val("carry_out", carry_out, sb_carry.pop_front());
         if (keep_valid) in_data = W'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      check_val("idle_busy", busy, 0);
      check_val("idle_out_valid", out_valid, 0);
      $display("[TB] op %0d: sum streamed, carry_out=%0b", op_id, carry_out);
      op_id++;
   endtask

   initial begin
      logic [255:0] a, b;
      int lat, la0, lb0, st0;

      clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_val("reset_outputs", {in_ready, out_valid, out_last, carry_out, busy, strobes()}, 0);
      clr = 1'b0;
      #1;
      check_val("post_reset_in_ready", in_ready, 1);
      check_val("post_reset_busy", busy, 0);

      // All-ones plus one: every word wraps to zero, carry out set.
      a = '1; b = 256'd1;
      send_op(a, b, 0);
      recv_op(-1, 0, 0, lat);
      check_val("latency", lat, WORDS + 1);

      // Alternating FFFF/0001 words with B=1: the carry ripples only into word 1.
      for (int k = 0; k < WORDS; k++) a[k*W +: W] = (k % 2) ? 16'h0001 : 16'hFFFF;
      b = 256'd1;
      send_op(a, b, 0);
      recv_op(-1, 0, 0, lat);

      // Zero operands with a 1010 in_valid pattern: exactly WORDS loads each.
      la0 = load_a_cnt; lb0 = load_b_cnt;
      send_op('0, '0, 1);
      recv_op(-1, 0, 0, lat);
      check_val("toggle_loads_a", load_a_cnt - la0, WORDS);
      check_val("toggle_loads_b", load_b_cnt - lb0, WORDS);

      // Output backpressure on word 7.
      send_op(rand256(), rand256(), 0);
      recv_op(7, 5, 0, lat);

      // Abort in ADD cycle 8, then a fresh small run.
      send_op(rand256(), rand256(), 0);
      @(negedge clk);
      in_valid = 1'b0;
      check_val("clrc_carry_clr", carry_clr, 1);
      check_val("clrc_in_ready", in_ready, 0);
      repeat (9) @(negedge clk);
      check_val("add8_dff_we", dff_we, 1);
      clr = 1'b1;
      #1;
      check_val("abort_strobes", strobes(), 0);
      @(negedge clk);
      clr = 1'b0;
      #1;
      check_val("abort_busy", busy, 0);
      check_val("abort_in_ready", in_ready, 1);
      check_val("abort_strobes_after", strobes(), 0);
      sb_word.delete();
      sb_carry.delete();
      send_op(256'd5, 256'd7, 0);
      recv_op(-1, 0, 0, lat);

      // in_valid held high through CLRC/ADD/OUT: no loads outside the input window.
      la0 = load_a_cnt; lb0 = load_b_cnt; st0 = stray_cnt;
      send_op(rand256(), rand256(), 0);
      recv_op(-1, 0, 1, lat);
      check_val("busy_hold_loads_a", load_a_cnt - la0, WORDS);
      check_val("busy_hold_loads_b", load_b_cnt - lb0, WORDS);
      check_val("busy_hold_stray", stray_cnt - st0, 0);

      check_val("protocol_stray_total", stray_cnt, 0);
      check_val("scoreboard_drained", 64'(sb_word.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
